// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: latches one load/store from the memory stage,
// drives a held request to data memory, and reports completion or bus error.
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lat_we;

  // Byte offset is carried by the mask; the memory only sees word addresses.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^address[1:0];

  assign stall = (state == ISSUE) | ((state == IDLE) & request);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      valid     <= 1'b1;
      load_data <= '0;
      bus_error <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_mask  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            lat_we <= we_re;
            valid  <= 1'b0;
            if (mask != 4'b0000) begin
              // mem_addr/mem_wdata double as the latched request registers.
              mem_addr  <= {address[31:2], 2'b00};
              mem_wdata <= store_data;
              mem_we    <= we_re;
              mem_mask  <= mask;
              mem_req   <= 1'b1;
              wait_cnt  <= '0;
              state     <= ISSUE;
            end else begin
              bus_error <= 1'b1;
              state     <= ERR;
            end
          end
        end

        ISSUE: begin
          if (mem_ack) begin
            if (!lat_we) begin
              load_data <= mem_rdata;
            end
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_mask <= '0;
            state    <= DONE;
          end else if (wait_cnt == LAST_WAIT) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_mask  <= '0;
            bus_error <= 1'b1;
            state     <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          valid <= 1'b1;
          state <= IDLE;
        end

        ERR: begin
          bus_error <= 1'b0;
          if (!lat_we) begin
            load_data <= '0;
          end
          valid <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          valid <= 1'b1;
        end
      endcase
    end
  end

endmodule
